// File: rtl/fnd_pkg.sv
// fnd_pkg: shared font table, blank code and anode helper for the FND scan controller
package fnd_pkg;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
    localparam logic [6:0] FONT_ROM [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [7:0] FONT_BLANK = 8'hFF;

    // n ones: every active-low anode switched off
    function automatic logic [31:0] digit_off(input int n);
        return (n >= 32) ? '1 : (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/fnd_font_rom.sv
// fnd_font_rom: nibble to active-low seven-segment glyph
//   i_nibble : hex value 0..F
//   o_seg    : active-low {g,f,e,d,c,b,a}
module fnd_font_rom
    import fnd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = FONT_ROM[i_nibble];

endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: time-multiplexed N-digit common-anode seven-segment driver
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_en           : display enable; low holds scanning at digit 0 and blanks outputs
//   i_value, i_dp  : packed nibbles and per-digit decimal points, snapshotted once per frame
//   i_lzb          : leading-zero blanking enable
//   o_digit        : active-low anodes, one-hot-low while lit
//   o_font         : active-low segments {dp,g,f,e,d,c,b,a}
//   o_frameDone    : one-cycle pulse after the last digit's slot completes
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 100_000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_lzb,
    output logic [NUM_DIGITS-1:0]   o_digit,
    output logic [7:0]              o_font,
    output logic                    o_frameDone
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF = NUM_DIGITS'(digit_off(NUM_DIGITS));

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   digit_q, digit_d;
    logic [7:0]              font_q, font_d;
    logic                    frame_q, frame_d;

    logic                    tick, wrap, lit, zrun;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              nib;
    logic [6:0]              glyph;

    assign nib = sh_value_q[{idx_q, 2'b00} +: 4];

    fnd_font_rom u_rom (
        .i_nibble (nib),
        .o_seg    (glyph)
    );

    // Scan down from the MSB; a digit blanks while every nibble above and including it is zero
    always_comb begin
        blank = '0;
        zrun  = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zrun     = zrun && (sh_value_q[4*k +: 4] == 4'd0);
            blank[k] = i_lzb && zrun;
        end
    end

    always_comb begin
        tick       = cnt_q == CW'(CLK_DIV - 1);
        wrap       = tick && idx_q == IW'(NUM_DIGITS - 1);
        cnt_d      = (!i_en || tick) ? '0 : cnt_q + 1'b1;
        idx_d      = (!i_en || wrap) ? '0 : tick ? idx_q + 1'b1 : idx_q;
        sh_value_d = (!i_en || wrap) ? i_value : sh_value_q;
        sh_dp_d    = (!i_en || wrap) ? i_dp : sh_dp_q;
        lit        = i_en && int'(cnt_q) >= DEAD_CYCLES;
        digit_d    = lit ? ~(NUM_DIGITS'(1) << idx_q) : ALL_OFF;
        font_d     = lit ? {~sh_dp_q[idx_q], blank[idx_q] ? 7'h7F : glyph} : FONT_BLANK;
        frame_d    = i_en && wrap;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_value_q <= '0;
            sh_dp_q    <= '0;
            digit_q    <= ALL_OFF;
            font_q     <= FONT_BLANK;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_value_q <= sh_value_d;
            sh_dp_q    <= sh_dp_d;
            digit_q    <= digit_d;
            font_q     <= font_d;
            frame_q    <= frame_d;
        end
    end

    assign o_digit     = digit_q;
    assign o_font      = font_q;
    assign o_frameDone = frame_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller: scoreboard bench with a frame-position reference model
module tb_fnd_scan_controller;

    localparam int N = 4;
    localparam int C = 4;
    localparam int D = 1;

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_en = 1'b0;
    logic [15:0]  i_value = '0;
    logic [3:0]   i_dp = '0;
    logic         i_lzb = 1'b0;
    logic [3:0]   o_digit;
    logic [7:0]   o_font;
    logic         o_frameDone;

    fnd_scan_controller #(.NUM_DIGITS(N), .CLK_DIV(C), .DEAD_CYCLES(D)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_en        (i_en),
        .i_value     (i_value),
        .i_dp        (i_dp),
        .i_lzb       (i_lzb),
        .o_digit     (o_digit),
        .o_font      (o_font),
        .o_frameDone (o_frameDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dig;
        logic [7:0] font;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // model: n = enabled cycles since scanning (re)started, snapshot of value/dp
    int         n = 0;
    logic [15:0] snap_v = '0;
    logic [3:0]  snap_d = '0;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic step(input logic r, input logic e, input logic [15:0] v,
                        input logic [3:0] dp, input logic lz);
        exp_t x;
        int   pos, d;
        logic [3:0] one;
        @(negedge clk);
        i_reset = r;
        i_en    = e;
        i_value = v;
        i_dp    = dp;
        i_lzb   = lz;
        one = 4'd1;
        pos = n % C;
        d   = (n / C) % N;
        x.dig  = 4'hF;
        x.font = 8'hFF;
        x.fd   = 1'b0;
        if (!r && e) begin
            x.fd = (pos == C - 1) && (d == N - 1);
            if (pos >= D) begin
                x.dig  = ~(one << d);
                x.font = {~snap_d[d],
                          (lz && d != 0 && (snap_v >> (4 * d)) == 16'd0) ? 7'h7F : hex7(snap_v[4*d +: 4])};
            end
        end
        q.push_back(x);
        if (r) begin
            n = 0; snap_v = '0; snap_d = '0;
        end else if (!e) begin
            n = 0; snap_v = v; snap_d = dp;
        end else begin
            if (x.fd) begin
                snap_v = v; snap_d = dp;
            end
            n = (n + 1) % (N * C);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) continue;
            x = q.pop_front();
            vectors++;
            if (o_digit !== x.dig || o_font !== x.font || o_frameDone !== x.fd) begin
                miscompares++;
                $display("FAIL vec%0d: digit=%b font=%h frameDone=%b, required digit=%b font=%h frameDone=%b",
                         vectors, o_digit, o_font, o_frameDone, x.dig, x.font, x.fd);
            end
        end
    end

    initial begin
        logic [15:0] v;
        // reset, then scan 1234 with a mid-frame change to ABCD during digit 2
        repeat (3) step(1, 0, 16'h1234, 4'h0, 0);
        step(0, 0, 16'h1234, 4'h0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, (i >= 9) ? 16'hABCD : 16'h1234, 4'h0, 0);
        // leading-zero blanking
        step(0, 0, 16'h0050, 4'h0, 1);
        repeat (17) step(0, 1, 16'h0050, 4'h0, 1);
        step(0, 0, 16'h0000, 4'h0, 1);
        repeat (17) step(0, 1, 16'h0000, 4'h0, 1);
        // decimal point, with and without blanking
        step(0, 0, 16'h8888, 4'b0100, 0);
        repeat (17) step(0, 1, 16'h8888, 4'b0100, 0);
        step(0, 0, 16'h0000, 4'b0100, 1);
        repeat (17) step(0, 1, 16'h0000, 4'b0100, 1);
        // disable during digit 1's lit window, then reset with enable held
        step(0, 0, 16'h1234, 4'h0, 0);
        repeat (6) step(0, 1, 16'h1234, 4'h0, 0);
        repeat (2) step(0, 0, 16'h1234, 4'h0, 0);
        repeat (10) step(0, 1, 16'h1234, 4'h0, 0);
        step(1, 1, 16'h1234, 4'h0, 0);
        repeat (20) step(0, 1, 16'h1234, 4'h0, 0);
        // randomized traffic with zero-heavy nibbles
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) v[4*k +: 4] = ($urandom_range(1) != 0) ? 4'd0 : 4'($urandom);
            step(($urandom_range(199) == 0), ($urandom_range(49) != 0), v, 4'($urandom), 1'($urandom));
        end
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d pending, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
